// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding and load-use hazard scoreboard for the pipelined MIPS core.
// Tracks in-flight destination registers over NUM_STAGES post-ID stages and
// produces ALU operand selects, a store-data forward select and a load-use
// stall that injects a bubble into stage 1 (EX).
// Select encoding: 0 = register file, 1 = shamt/immediate, k+1 = stage k.
// Optional feature macro: FWD_STALL_STATS_EN adds a saturating StallCount.
module fwd_hazard_scoreboard #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned LOAD_STAGE = 2,
    localparam int unsigned SEL_W = $clog2(NUM_STAGES + 2)
) (
    input  logic                  CLK,
    input  logic                  Reset,
    input  logic                  Freeze,
    input  logic                  ID_Valid,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic [REG_ADDR_W-1:0] ID_Rw,
    input  logic                  ID_RegWrite,
    input  logic                  ID_MemRead,
    input  logic                  ID_MemWrite,
    input  logic                  UseShamt,
    input  logic                  UseImmed,
    output logic [SEL_W-1:0]      AluOpCtrlA,
    output logic [SEL_W-1:0]      AluOpCtrlB,
    output logic [SEL_W-1:0]      StoreFwdSel,
    output logic                  Stall
`ifdef FWD_STALL_STATS_EN
    ,
    output logic [15:0]           StallCount
`endif
);

    // Tracking entry per stage; index i holds stage i+1 (index 0 = EX).
    logic [NUM_STAGES-1:0] ent_valid;
    logic [NUM_STAGES-1:0] ent_regwrite;
    logic [NUM_STAGES-1:0] ent_memread;
    logic [REG_ADDR_W-1:0] ent_rw [NUM_STAGES];

    logic [NUM_STAGES-1:0] rs_match;
    logic [NUM_STAGES-1:0] rt_match;
    logic [SEL_W-1:0]      rs_sel;
    logic [SEL_W-1:0]      rt_sel;
    logic                  rs_load_early;
    logic                  rt_load_early;
    logic                  rs_needed;
    logic                  rt_needed;

    // Per-stage match: a live writer of a non-zero register equal to the source.
    always_comb begin
        rs_match = '0;
        rt_match = '0;
        for (int i = 0; i < int'(NUM_STAGES); i++) begin
            rs_match[i] = ent_valid[i] && ent_regwrite[i] && (ent_rw[i] != '0) && (ent_rw[i] == ID_Rs);
            rt_match[i] = ent_valid[i] && ent_regwrite[i] && (ent_rw[i] != '0) && (ent_rw[i] == ID_Rt);
        end
    end

    // Youngest match wins: scan oldest to youngest so the smallest stage overwrites.
    // A match is a load hazard when it is a load that has not yet reached LOAD_STAGE.
    always_comb begin
        rs_sel        = '0;
        rt_sel        = '0;
        rs_load_early = 1'b0;
        rt_load_early = 1'b0;
        for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
            if (rs_match[i]) begin
                rs_sel        = SEL_W'(i + 2);
                rs_load_early = ent_memread[i] && ((i + 1) < int'(LOAD_STAGE));
            end
            if (rt_match[i]) begin
                rt_sel        = SEL_W'(i + 2);
                rt_load_early = ent_memread[i] && ((i + 1) < int'(LOAD_STAGE));
            end
        end
    end

    // Operand selects and load-use stall, zero latency from state and ID inputs.
    always_comb begin
        rs_needed   = !UseShamt;
        rt_needed   = !UseImmed || ID_MemWrite;
        AluOpCtrlA  = UseShamt ? SEL_W'(1) : rs_sel;
        AluOpCtrlB  = UseImmed ? SEL_W'(1) : rt_sel;
        StoreFwdSel = rt_sel;
        Stall       = ID_Valid && ((rs_needed && rs_load_early) || (rt_needed && rt_load_early));
    end

    // Tracking pipeline: bubble on stall or invalid ID, hold on Freeze, Reset dominates.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            ent_valid    <= '0;
            ent_regwrite <= '0;
            ent_memread  <= '0;
            for (int i = 0; i < int'(NUM_STAGES); i++) begin
                ent_rw[i] <= '0;
            end
        end else if (!Freeze) begin
            for (int i = int'(NUM_STAGES) - 1; i > 0; i--) begin
                ent_valid[i]    <= ent_valid[i-1];
                ent_regwrite[i] <= ent_regwrite[i-1];
                ent_memread[i]  <= ent_memread[i-1];
                ent_rw[i]       <= ent_rw[i-1];
            end
            ent_valid[0]    <= ID_Valid && !Stall;
            ent_regwrite[0] <= ID_RegWrite;
            ent_memread[0]  <= ID_MemRead;
            ent_rw[0]       <= ID_Rw;
        end
    end

`ifdef FWD_STALL_STATS_EN
    // Saturating count of cycles actually lost to load-use stalls.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            StallCount <= '0;
        end else if (Stall && !Freeze && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Self-checking bench for fwd_hazard_scoreboard: three parameterisations
// share one stimulus stream; directed table, hand sequences and random
// stimulus checked against an in-flight instruction history model.
module tb_fwd_hazard_scoreboard;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic       Reset, Freeze, ID_Valid, ID_RegWrite, ID_MemRead, ID_MemWrite, UseShamt, UseImmed;
    logic [4:0] ID_Rs, ID_Rt, ID_Rw;
    logic [1:0] a0, b0, s0;
    logic [2:0] a1, b1, s1, a2, b2, s2;
    logic       st0, st1, st2;
`ifdef FWD_STALL_STATS_EN
    logic [15:0] c0, c1, c2;
`endif

    fwd_hazard_scoreboard #(.REG_ADDR_W(5), .NUM_STAGES(2), .LOAD_STAGE(2)) dut0 (
        .CLK(CLK), .Reset(Reset), .Freeze(Freeze), .ID_Valid(ID_Valid),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rw(ID_Rw), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .UseShamt(UseShamt), .UseImmed(UseImmed),
        .AluOpCtrlA(a0), .AluOpCtrlB(b0), .StoreFwdSel(s0), .Stall(st0)
`ifdef FWD_STALL_STATS_EN
        , .StallCount(c0)
`endif
    );

    fwd_hazard_scoreboard #(.REG_ADDR_W(5), .NUM_STAGES(3), .LOAD_STAGE(3)) dut1 (
        .CLK(CLK), .Reset(Reset), .Freeze(Freeze), .ID_Valid(ID_Valid),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rw(ID_Rw), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .UseShamt(UseShamt), .UseImmed(UseImmed),
        .AluOpCtrlA(a1), .AluOpCtrlB(b1), .StoreFwdSel(s1), .Stall(st1)
`ifdef FWD_STALL_STATS_EN
        , .StallCount(c1)
`endif
    );

    fwd_hazard_scoreboard #(.REG_ADDR_W(5), .NUM_STAGES(6), .LOAD_STAGE(4)) dut2 (
        .CLK(CLK), .Reset(Reset), .Freeze(Freeze), .ID_Valid(ID_Valid),
        .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_Rw(ID_Rw), .ID_RegWrite(ID_RegWrite),
        .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite), .UseShamt(UseShamt), .UseImmed(UseImmed),
        .AluOpCtrlA(a2), .AluOpCtrlB(b2), .StoreFwdSel(s2), .Stall(st2)
`ifdef FWD_STALL_STATS_EN
        , .StallCount(c2)
`endif
    );

    localparam int NS [3] = '{2, 3, 6};
    localparam int LS [3] = '{2, 3, 4};

    typedef struct {
        logic       rst, frz, vld;
        logic [4:0] rs, rt, rw;
        logic       rwr, mr, mw, sh, im;
    } in_t;

    typedef struct {
        in_t x;
        int  ea, eb, es, est;
    } vec_t;

    // Model: history of what entered EX in each of the last cycles (index 0 = youngest).
    typedef struct {
        logic       v, wr, mr;
        logic [4:0] rw;
    } ent_t;

    ent_t m [3][6];
    int   mcnt [3];
    int   sa [3], sb [3], ss [3], sst [3];
    int   ntests = 0;
    int   nfail  = 0;

    function automatic in_t mki(input logic rst, frz, vld, input int rs, rt, rw,
                                input logic rwr, mr, mw, sh, im);
        in_t x;
        x.rst = rst; x.frz = frz; x.vld = vld;
        x.rs = 5'(rs); x.rt = 5'(rt); x.rw = 5'(rw);
        x.rwr = rwr; x.mr = mr; x.mw = mw; x.sh = sh; x.im = im;
        return x;
    endfunction

    function automatic vec_t mkv(input in_t x, input int ea, eb, es, est);
        vec_t v;
        v.x = x; v.ea = ea; v.eb = eb; v.es = es; v.est = est;
        return v;
    endfunction

    function automatic int young(input int d, input logic [4:0] src);
        for (int k = 1; k <= NS[d]; k++) begin
            if (m[d][k-1].v && m[d][k-1].wr && src != 5'd0 && m[d][k-1].rw == src) return k;
        end
        return 0;
    endfunction

    function automatic void model_out(input int d, input in_t x, output int ea, eb, es, est);
        int ka, kb;
        ka  = young(d, x.rs);
        kb  = young(d, x.rt);
        ea  = x.sh ? 1 : (ka != 0 ? ka + 1 : 0);
        eb  = x.im ? 1 : (kb != 0 ? kb + 1 : 0);
        es  = (kb != 0) ? kb + 1 : 0;
        est = 0;
        if (x.vld) begin
            if (!x.sh && ka != 0 && m[d][ka-1].mr && ka < LS[d]) est = 1;
            if ((!x.im || x.mw) && kb != 0 && m[d][kb-1].mr && kb < LS[d]) est = 1;
        end
    endfunction

    function automatic void model_step(input int d, input in_t x, input int est);
        if (x.rst) begin
            for (int k = 0; k < 6; k++) m[d][k].v = 1'b0;
            mcnt[d] = 0;
        end else if (!x.frz) begin
            if (est != 0 && mcnt[d] < 65535) mcnt[d]++;
            for (int k = NS[d] - 1; k > 0; k--) m[d][k] = m[d][k-1];
            m[d][0].v  = x.vld && (est == 0);
            m[d][0].wr = x.rwr;
            m[d][0].mr = x.mr;
            m[d][0].rw = x.rw;
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        ntests++;
        if (got != exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // One clock: drive, sample outputs mid-cycle, optionally check vs model, advance model.
    task automatic cycle(input in_t x, input bit mchk);
        int ea, eb, es, est;
        int stv [3];
        Reset = x.rst; Freeze = x.frz; ID_Valid = x.vld;
        ID_Rs = x.rs; ID_Rt = x.rt; ID_Rw = x.rw;
        ID_RegWrite = x.rwr; ID_MemRead = x.mr; ID_MemWrite = x.mw;
        UseShamt = x.sh; UseImmed = x.im;
        #2;
        sa[0] = int'(a0); sb[0] = int'(b0); ss[0] = int'(s0); sst[0] = int'(st0);
        sa[1] = int'(a1); sb[1] = int'(b1); ss[1] = int'(s1); sst[1] = int'(st1);
        sa[2] = int'(a2); sb[2] = int'(b2); ss[2] = int'(s2); sst[2] = int'(st2);
        for (int d = 0; d < 3; d++) begin
            model_out(d, x, ea, eb, es, est);
            stv[d] = est;
            if (mchk) begin
                chk($sformatf("model A d%0d", d), sa[d], ea);
                chk($sformatf("model B d%0d", d), sb[d], eb);
                chk($sformatf("model SF d%0d", d), ss[d], es);
                chk($sformatf("model Stall d%0d", d), sst[d], est);
            end
        end
        @(posedge CLK);
        for (int d = 0; d < 3; d++) model_step(d, x, stv[d]);
        #1;
`ifdef FWD_STALL_STATS_EN
        if (mchk) begin
            chk("model StallCount d0", int'(c0), mcnt[0]);
            chk("model StallCount d1", int'(c1), mcnt[1]);
            chk("model StallCount d2", int'(c2), mcnt[2]);
        end
`endif
    endtask

    vec_t tbl [19];
    in_t  rst_x, idle_x, x;

    initial begin
        for (int d = 0; d < 3; d++) begin
            mcnt[d] = 0;
            for (int k = 0; k < 6; k++) m[d][k] = '{1'b0, 1'b0, 1'b0, 5'd0};
        end
        rst_x  = mki(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle_x = mki(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //                 rst frz vld rs  rt  rw  rwr mr mw sh im     A  B  SF St
        tbl[0]  = mkv(mki(1, 0, 0,  0,  0,  0, 0, 0, 0, 1, 0), 1, 0, 0, 0);
        tbl[1]  = mkv(mki(0, 0, 1,  0,  0,  3, 1, 0, 0, 0, 0), 0, 0, 0, 0);
        tbl[2]  = mkv(mki(0, 0, 1,  3,  3, 10, 1, 0, 0, 0, 0), 2, 2, 2, 0);
        tbl[3]  = mkv(mki(0, 0, 1,  3, 10,  5, 1, 0, 0, 0, 0), 3, 2, 2, 0);
        tbl[4]  = mkv(mki(0, 0, 1,  5,  0,  7, 1, 0, 0, 0, 0), 2, 0, 0, 0);
        tbl[5]  = mkv(mki(0, 0, 1,  5,  7,  5, 1, 0, 0, 0, 0), 3, 2, 2, 0);
        tbl[6]  = mkv(mki(0, 0, 1,  5,  0,  5, 1, 0, 0, 0, 0), 2, 0, 0, 0);
        tbl[7]  = mkv(mki(0, 0, 1,  5,  5,  4, 1, 1, 0, 0, 0), 2, 2, 2, 0);
        tbl[8]  = mkv(mki(0, 0, 1,  4,  0,  9, 1, 0, 0, 0, 1), 2, 1, 0, 1);
        tbl[9]  = mkv(mki(0, 0, 1,  4,  0,  9, 1, 0, 0, 0, 1), 3, 1, 0, 0);
        tbl[10] = mkv(mki(0, 0, 1,  9,  0,  0, 1, 0, 0, 0, 0), 2, 0, 0, 0);
        tbl[11] = mkv(mki(0, 0, 1,  0,  0, 12, 1, 0, 0, 0, 0), 0, 0, 0, 0);
        tbl[12] = mkv(mki(0, 0, 1, 12, 12,  0, 0, 0, 1, 1, 1), 1, 1, 2, 0);
        tbl[13] = mkv(mki(0, 0, 1, 12, 12,  6, 1, 1, 0, 0, 0), 3, 3, 3, 0);
        tbl[14] = mkv(mki(0, 0, 1,  0,  6,  0, 0, 0, 1, 0, 1), 0, 1, 2, 1);
        tbl[15] = mkv(mki(0, 0, 1,  0,  6,  8, 1, 1, 0, 0, 0), 0, 3, 3, 0);
        tbl[16] = mkv(mki(0, 0, 0,  8,  0,  0, 0, 0, 0, 0, 0), 2, 0, 0, 0);
        tbl[17] = mkv(mki(0, 0, 1,  8,  0, 13, 0, 0, 0, 0, 0), 3, 0, 0, 0);
        tbl[18] = mkv(mki(0, 0, 1, 13, 13,  0, 0, 0, 0, 0, 0), 0, 0, 0, 0);

        @(posedge CLK); #1;
        cycle(rst_x, 1'b0);

        // Directed table on the default configuration.
        for (int i = 0; i < 19; i++) begin
            cycle(tbl[i].x, 1'b1);
            chk($sformatf("tbl%0d A", i), sa[0], tbl[i].ea);
            chk($sformatf("tbl%0d B", i), sb[0], tbl[i].eb);
            chk($sformatf("tbl%0d SF", i), ss[0], tbl[i].es);
            chk($sformatf("tbl%0d Stall", i), sst[0], tbl[i].est);
        end

        // Freeze holds a load in EX: stall persists, then exactly one more stall cycle.
        cycle(rst_x, 1'b1);
        cycle(mki(0, 0, 1, 0, 0, 6, 1, 1, 0, 0, 0), 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(mki(0, 1, 1, 6, 0, 0, 0, 0, 0, 0, 1), 1'b1);
            chk($sformatf("frz%0d Stall", i), sst[0], 1);
            chk($sformatf("frz%0d A", i), sa[0], 2);
        end
        cycle(mki(0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 1), 1'b1);
        chk("frz release Stall", sst[0], 1);
        cycle(mki(0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 1), 1'b1);
        chk("frz after Stall", sst[0], 0);
        chk("frz after A", sa[0], 3);
        cycle(mki(0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 1), 1'b1);
        chk("frz drained A", sa[0], 0);

        // Reset asserted during a stall clears everything.
        cycle(mki(0, 0, 1, 0, 0, 6, 1, 1, 0, 0, 0), 1'b1);
        cycle(mki(1, 0, 1, 6, 6, 0, 0, 0, 0, 0, 0), 1'b1);
        chk("rst mid Stall", sst[0], 1);
        cycle(mki(0, 0, 1, 6, 6, 0, 0, 0, 0, 0, 0), 1'b1);
        chk("rst after Stall", sst[0], 0);
        chk("rst after A", sa[0], 0);
        chk("rst after B", sb[0], 0);
        chk("rst after SF", ss[0], 0);
        chk("rst after Stall d1", sst[1], 0);

        // Three tracked stages, load data at stage 3: two-cycle load-use stall.
        cycle(rst_x, 1'b1);
        cycle(mki(0, 0, 1, 0, 0, 7, 1, 1, 0, 0, 0), 1'b1);
        chk("p3 issue Stall", sst[1], 0);
        cycle(mki(0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1), 1'b1);
        chk("p3 c1 Stall", sst[1], 1);
        chk("p3 c1 A", sa[1], 2);
        cycle(mki(0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1), 1'b1);
        chk("p3 c2 Stall", sst[1], 1);
        chk("p3 c2 A", sa[1], 3);
        cycle(mki(0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 1), 1'b1);
        chk("p3 c3 Stall", sst[1], 0);
        chk("p3 c3 A", sa[1], 4);
`ifdef FWD_STALL_STATS_EN
        chk("p3 StallCount", int'(c1), 2);
`endif

        // Random stimulus against the model on all three configurations.
        for (int n = 0; n < 3000; n++) begin
            x = mki($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) != 0,
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
            cycle(x, 1'b1);
        end
        cycle(idle_x, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
